// File: rtl/sm_knn_vote.sv
`default_nettype none
// sm_knn_vote: snapshots VECT_NUM distance/label pairs, keeps the K nearest in a sorted list and votes a label.
// Optional macro KNN_WEIGHTED_EN: rank-weighted vote (rank r counts K-r). Rev 1.0
module sm_knn_vote #(
  parameter int SUM_LEN  = 10,
  parameter int LBL_LEN  = 10,
  parameter int VECT_NUM = 6,
  parameter int K        = 3,
`ifdef KNN_WEIGHTED_EN
  localparam int CNT_LEN = $clog2(K * (K + 1) / 2 + 1)
`else
  localparam int CNT_LEN = $clog2(K + 1)
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SUM_LEN-1:0] inS [VECT_NUM],
  input  logic [LBL_LEN-1:0] inL [VECT_NUM],
  output logic               busy,
  output logic               done,
  output logic [LBL_LEN-1:0] outL,
  output logic [SUM_LEN-1:0] outS,
  output logic [CNT_LEN-1:0] outCnt
);

  localparam int IDX_W = (VECT_NUM > 1) ? $clog2(VECT_NUM) : 1;
  localparam int J_W   = (K > 1) ? $clog2(K) : 1;
  localparam int POS_W = $clog2(K + 1);

  generate
    if (K < 1 || K > VECT_NUM) begin : g_bad_k
      $error("sm_knn_vote: K must satisfy 1 <= K <= VECT_NUM");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    VOTE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [IDX_W-1:0]   idx;
  logic [J_W-1:0]     j;
  logic [SUM_LEN-1:0] snap_s [VECT_NUM];
  logic [LBL_LEN-1:0] snap_l [VECT_NUM];
  logic [SUM_LEN-1:0] lst_s  [K];
  logic [LBL_LEN-1:0] lst_l  [K];
  logic               lst_v  [K];
  logic [LBL_LEN-1:0] best_l;
  logic [CNT_LEN-1:0] best_c;

  logic capture, scan_en, vote_en, commit;
  logic last_idx, last_j;

  assign last_idx = (idx == IDX_W'(VECT_NUM - 1));
  assign last_j   = (j == J_W'(K - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    scan_en    = 1'b0;
    vote_en    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (last_idx) next_state = VOTE;
      end
      VOTE: begin
        vote_en = 1'b1;
        if (last_j) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Insertion point = number of valid entries with sum <= candidate, so equal sums stay in arrival order.
  logic [SUM_LEN-1:0] cand_s;
  logic [LBL_LEN-1:0] cand_l;
  logic [POS_W-1:0]   pos;
  logic [SUM_LEN-1:0] ins_s [K];
  logic [LBL_LEN-1:0] ins_l [K];
  logic               ins_v [K];

  always_comb begin
    cand_s = snap_s[idx];
    cand_l = snap_l[idx];
    pos    = '0;
    for (int i = 0; i < K; i++) begin
      if (lst_v[i] && (lst_s[i] <= cand_s)) pos = pos + POS_W'(1);
    end
    if (pos == '0) begin
      ins_s[0] = cand_s;
      ins_l[0] = cand_l;
      ins_v[0] = 1'b1;
    end else begin
      ins_s[0] = lst_s[0];
      ins_l[0] = lst_l[0];
      ins_v[0] = lst_v[0];
    end
    for (int i = 1; i < K; i++) begin
      if (int'(pos) == i) begin
        ins_s[i] = cand_s;
        ins_l[i] = cand_l;
        ins_v[i] = 1'b1;
      end else if (int'(pos) < i) begin
        ins_s[i] = lst_s[i-1];
        ins_l[i] = lst_l[i-1];
        ins_v[i] = lst_v[i-1];
      end else begin
        ins_s[i] = lst_s[i];
        ins_l[i] = lst_l[i];
        ins_v[i] = lst_v[i];
      end
    end
  end

  logic [LBL_LEN-1:0] cur_l;
  logic [CNT_LEN-1:0] vote_cnt;
  logic               better;
  logic [LBL_LEN-1:0] nb_l;
  logic [CNT_LEN-1:0] nb_c;

  always_comb begin
    cur_l    = lst_l[j];
    vote_cnt = '0;
    for (int i = 0; i < K; i++) begin
      if (lst_v[i] && (lst_l[i] == cur_l)) begin
`ifdef KNN_WEIGHTED_EN
        vote_cnt = vote_cnt + CNT_LEN'(K - i);
`else
        vote_cnt = vote_cnt + CNT_LEN'(1);
`endif
      end
    end
    // Strictly greater keeps the earlier (nearer) label on ties.
    better = (vote_cnt > best_c);
    nb_l   = better ? cur_l : best_l;
    nb_c   = better ? vote_cnt : best_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      j      <= '0;
      best_l <= '0;
      best_c <= '0;
      done   <= 1'b0;
      outL   <= '0;
      outS   <= '0;
      outCnt <= '0;
      for (int v = 0; v < VECT_NUM; v++) begin
        snap_s[v] <= '0;
        snap_l[v] <= '0;
      end
      for (int i = 0; i < K; i++) begin
        lst_s[i] <= '1;
        lst_l[i] <= '0;
        lst_v[i] <= 1'b0;
      end
    end else begin
      done <= commit;
      if (capture) begin
        for (int v = 0; v < VECT_NUM; v++) begin
          snap_s[v] <= inS[v];
          snap_l[v] <= inL[v];
        end
        for (int i = 0; i < K; i++) begin
          lst_s[i] <= '1;
          lst_l[i] <= '0;
          lst_v[i] <= 1'b0;
        end
        idx    <= '0;
        j      <= '0;
        best_l <= '0;
        best_c <= '0;
      end
      if (scan_en) begin
        for (int i = 0; i < K; i++) begin
          lst_s[i] <= ins_s[i];
          lst_l[i] <= ins_l[i];
          lst_v[i] <= ins_v[i];
        end
        if (!last_idx) idx <= idx + IDX_W'(1);
      end
      if (vote_en) begin
        best_l <= nb_l;
        best_c <= nb_c;
        if (!last_j) j <= j + J_W'(1);
      end
      if (commit) begin
        outL   <= nb_l;
        outCnt <= nb_c;
        outS   <= lst_s[0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_knn_vote.sv
`default_nettype none
// Testbench for sm_knn_vote: directed vectors plus random sets checked against a sort-and-count model.
module tb_sm_knn_vote;
  localparam int SUM_LEN  = 10;
  localparam int LBL_LEN  = 10;
  localparam int VECT_NUM = 6;
  localparam int K        = 3;
  localparam int LAT      = VECT_NUM + K;
`ifdef KNN_WEIGHTED_EN
  localparam int CNT_LEN = $clog2(K * (K + 1) / 2 + 1);
`else
  localparam int CNT_LEN = $clog2(K + 1);
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [SUM_LEN-1:0] inS [VECT_NUM];
  logic [LBL_LEN-1:0] inL [VECT_NUM];
  logic               busy, done;
  logic [LBL_LEN-1:0] outL;
  logic [SUM_LEN-1:0] outS;
  logic [CNT_LEN-1:0] outCnt;

  sm_knn_vote #(.SUM_LEN(SUM_LEN), .LBL_LEN(LBL_LEN), .VECT_NUM(VECT_NUM), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .inS(inS), .inL(inL),
    .busy(busy), .done(done), .outL(outL), .outS(outS), .outCnt(outCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [SUM_LEN-1:0] ms [VECT_NUM];
  logic [LBL_LEN-1:0] ml [VECT_NUM];
  logic [LBL_LEN-1:0] exp_l;
  logic [SUM_LEN-1:0] exp_s;
  logic [CNT_LEN-1:0] exp_c;

  // Reference: stable sort of all pairs by sum, keep first K, count votes per rank.
  task automatic model();
    int ord[$];
    int p, cnt, best;
    for (int v = 0; v < VECT_NUM; v++) begin
      p = ord.size();
      for (int q = 0; q < ord.size(); q++) begin
        if (ms[ord[q]] > ms[v]) begin
          p = q;
          break;
        end
      end
      ord.insert(p, v);
    end
    best  = 0;
    exp_l = '0;
    for (int r = 0; r < K; r++) begin
      cnt = 0;
      for (int q = 0; q < K; q++) begin
        if (ml[ord[q]] == ml[ord[r]]) begin
`ifdef KNN_WEIGHTED_EN
          cnt += K - q;
`else
          cnt += 1;
`endif
        end
      end
      if (cnt > best) begin
        best  = cnt;
        exp_l = ml[ord[r]];
      end
    end
    exp_s = ms[ord[0]];
    exp_c = CNT_LEN'(best);
  endtask

  task automatic rand_set();
    for (int v = 0; v < VECT_NUM; v++) begin
      ms[v] = ($urandom_range(0, 7) == 0) ? '1 : SUM_LEN'($urandom_range(0, 15));
      ml[v] = LBL_LEN'($urandom_range(0, 3));
    end
  endtask

  task automatic load();
    for (int v = 0; v < VECT_NUM; v++) begin
      inS[v] = ms[v];
      inL[v] = ml[v];
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    for (int v = 0; v < VECT_NUM; v++) begin
      inS[v] = '0;
      inL[v] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (outL !== '0) begin errors++; $display("FAIL reset_outL got %0d want 0", outL); end
    checks++; if (outS !== '0) begin errors++; $display("FAIL reset_outS got %0d want 0", outS); end
    checks++; if (outCnt !== '0) begin errors++; $display("FAIL reset_outCnt got %0d want 0", outCnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed_vectors();
    int ts [4][VECT_NUM] = '{'{40, 10, 30, 20, 50, 60}, '{7, 3, 9, 1, 8, 8},
                             '{12, 12, 12, 12, 12, 12}, '{1023, 1023, 1023, 1023, 1023, 5}};
    int tl [4][VECT_NUM] = '{'{1, 2, 1, 2, 3, 3}, '{4, 5, 6, 7, 8, 9},
                             '{1, 2, 2, 3, 3, 3}, '{1, 1, 2, 2, 3, 3}};
    int es [4] = '{10, 1, 12, 5};
`ifdef KNN_WEIGHTED_EN
    int el [4] = '{2, 7, 1, 3};
    int ec [4] = '{5, 3, 3, 3};
`else
    int el [4] = '{2, 7, 2, 1};
    int ec [4] = '{2, 1, 2, 2};
`endif
    int  lat;
    bit  ok;
    for (int c = 0; c < 4; c++) begin
      for (int v = 0; v < VECT_NUM; v++) begin
        ms[v] = SUM_LEN'(ts[c][v]);
        ml[v] = LBL_LEN'(tl[c][v]);
      end
      load();
      do_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fixed%0d_busy got %0b want 1", c, busy); end
      wait_done(lat, ok);
      checks++; if (ok !== 1'b1 || lat != LAT) begin errors++; $display("FAIL fixed%0d_latency got %0d (ok=%0b) want %0d", c, lat, ok, LAT); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixed%0d_busy_fall got %0b want 0", c, busy); end
      checks++; if (outL !== LBL_LEN'(el[c])) begin errors++; $display("FAIL fixed%0d_outL got %0d want %0d", c, outL, el[c]); end
      checks++; if (outS !== SUM_LEN'(es[c])) begin errors++; $display("FAIL fixed%0d_outS got %0d want %0d", c, outS, es[c]); end
      checks++; if (outCnt !== CNT_LEN'(ec[c])) begin errors++; $display("FAIL fixed%0d_outCnt got %0d want %0d", c, outCnt, ec[c]); end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL fixed%0d_done_pulse got %0b want 0", c, done); end
    end
  endtask

  task automatic test_snapshot_filter();
    int ndone = 0;
    int lat   = 0;
    rand_set();
    load();
    model();
    do_start();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      for (int v = 0; v < VECT_NUM; v++) begin
        inS[v] = SUM_LEN'($urandom_range(0, 1023));
        inL[v] = LBL_LEN'($urandom_range(0, 7));
      end
      start = (c == 2);
    end
    start = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL snap_done_count got %0d want 1", ndone); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL snap_latency got %0d want %0d", lat, LAT); end
    checks++; if (outL !== exp_l) begin errors++; $display("FAIL snap_outL got %0d want %0d", outL, exp_l); end
    checks++; if (outS !== exp_s) begin errors++; $display("FAIL snap_outS got %0d want %0d", outS, exp_s); end
    checks++; if (outCnt !== exp_c) begin errors++; $display("FAIL snap_outCnt got %0d want %0d", outCnt, exp_c); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    rand_set();
    load();
    model();
    do_start();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", done); end
    checks++; if (outL !== '0 || outS !== '0 || outCnt !== '0) begin
      errors++; $display("FAIL midrst_outputs got L=%0d S=%0d C=%0d want 0", outL, outS, outCnt);
    end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got done=%0b busy=%0b want 0", done, busy); end
    do_start();
    wait_done(lat, ok);
    checks++; if (ok !== 1'b1 || lat != LAT) begin errors++; $display("FAIL midrst_latency got %0d (ok=%0b) want %0d", lat, ok, LAT); end
    checks++; if (outL !== exp_l) begin errors++; $display("FAIL midrst_outL got %0d want %0d", outL, exp_l); end
    checks++; if (outS !== exp_s) begin errors++; $display("FAIL midrst_outS got %0d want %0d", outS, exp_s); end
    checks++; if (outCnt !== exp_c) begin errors++; $display("FAIL midrst_outCnt got %0d want %0d", outCnt, exp_c); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    rand_set();
    load();
    model();
    do_start();
    wait_done(lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_done got timeout want done"); end
    checks++; if (outL !== exp_l || outS !== exp_s || outCnt !== exp_c) begin
      errors++; $display("FAIL b2b_first got L=%0d S=%0d C=%0d want L=%0d S=%0d C=%0d", outL, outS, outCnt, exp_l, exp_s, exp_c);
    end
    rand_set();
    load();
    model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%0b want 1", busy); end
    wait_done(lat, ok);
    checks++; if (ok !== 1'b1 || lat != LAT) begin errors++; $display("FAIL b2b_latency got %0d (ok=%0b) want %0d", lat, ok, LAT); end
    checks++; if (outL !== exp_l || outS !== exp_s || outCnt !== exp_c) begin
      errors++; $display("FAIL b2b_second got L=%0d S=%0d C=%0d want L=%0d S=%0d C=%0d", outL, outS, outCnt, exp_l, exp_s, exp_c);
    end
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    for (int n = 0; n < 15; n++) begin
      rand_set();
      load();
      model();
      do_start();
      wait_done(lat, ok);
      checks++; if (ok !== 1'b1 || lat != LAT) begin errors++; $display("FAIL rand%0d_latency got %0d (ok=%0b) want %0d", n, lat, ok, LAT); end
      checks++; if (outL !== exp_l) begin errors++; $display("FAIL rand%0d_outL got %0d want %0d", n, outL, exp_l); end
      checks++; if (outS !== exp_s) begin errors++; $display("FAIL rand%0d_outS got %0d want %0d", n, outS, exp_s); end
      checks++; if (outCnt !== exp_c) begin errors++; $display("FAIL rand%0d_outCnt got %0d want %0d", n, outCnt, exp_c); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_vectors();
    test_snapshot_filter();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_knn_vote.md
Name: sm_knn_vote

Overview:
- Consumer end of the distance array interface: takes the per-vector sums and labels (one pair per stored vector) and classifies the current argument.
- Snapshots all VECT_NUM sum/label pairs on start and scans them one per cycle into a sorted list of the K nearest.
- Runs a majority vote over that list and reports the winning label, its vote count and the best distance.
- Sits directly after the systolic column array; the top-level controller raises start once the sums have settled.

Parameters:
- SUM_LEN, 10: width of each distance sum.
- LBL_LEN, 10: width of each label.
- VECT_NUM, 6: number of stored vectors, i.e. number of sum/label inputs.
- K, 3: number of nearest neighbours kept. Constraint 1 <= K <= VECT_NUM; violation is an elaboration error.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin classification; sampled only in IDLE.
- inS, input, [SUM_LEN-1:0] x VECT_NUM: distance sums, unpacked array indexed by vector.
- inL, input, [LBL_LEN-1:0] x VECT_NUM: labels, unpacked array indexed by vector.
- busy, output, 1: high while state != IDLE.
- done, output, 1: one-cycle pulse when the result registers update.
- outL, output, LBL_LEN: winning label.
- outS, output, SUM_LEN: smallest distance (list entry 0).
- outCnt, output, CNT_LEN: winning vote total. CNT_LEN = $clog2(K+1), or $clog2(K*(K+1)/2+1) with the optional feature.

Behaviour:
- Reset: state=IDLE; busy, done, outL, outS, outCnt all 0; sorted list cleared (valid=0, sum=all-ones).
- Reset mid-operation aborts the run. done is not pulsed and outputs are 0 on the next cycle.
- States: IDLE, SCAN, VOTE.
- IDLE: on the edge where start=1:
  - capture inS/inL into the snapshot registers;
  - clear the list;
  - idx=0; go to SCAN.
  - Inputs are not used after the capture edge.
- SCAN, one candidate per cycle, idx = 0..VECT_NUM-1:
  - insert snap[idx] into the K-entry ascending list;
  - the candidate goes after every entry with sum <= its sum, so equal sums keep lower-index-first order;
  - a candidate past position K-1 is dropped; entries shifted past K-1 are discarded;
  - after idx=VECT_NUM-1, go to VOTE with j=0.
- VOTE, one list entry per cycle, j = 0..K-1:
  - compute the count of valid entries whose label equals list[j].label (combinational across K entries);
  - replace the best (label, count) only if the count is strictly greater, so ties resolve to the lower rank (nearer neighbour);
  - on j=K-1, commit outL/outCnt from the best pair and outS=list[0].sum, pulse done=1, go to IDLE.
- Latency: start sampled at edge T gives done and the new outputs at edge T+VECT_NUM+K; busy falls on the same edge.
- done is high for exactly one cycle. Outputs hold until the next commit or reset.
- start while busy is ignored, with no queuing. start in the cycle done is high is accepted, because the state is already IDLE.
- Sums are plain unsigned. All-ones (saturated) sums are valid values, not "empty".
- Comparisons are unsigned, full SUM_LEN wide.

Optional Feature:
- Macro KNN_WEIGHTED_EN.
- Defined: rank r (0 = nearest) contributes weight K-r. The VOTE count is the sum of weights over entries matching list[j].label. The tie rule is unchanged, and CNT_LEN grows as stated above.
- Undefined: every entry contributes 1 (plain majority).

Test Plan (VECT_NUM=6, K=3):
- Basic nearest-neighbour: inS={40,10,30,20,50,60}, inL={1,2,1,2,3,3}, start at T -> done at T+9, outL=2, outS=10, outCnt=2. Weighted: outL=2, outCnt=5.
- Three-way tie: inS={7,3,9,1,8,8}, inL={4,5,6,7,8,9} -> top3 labels 7,5,4 each count 1 -> outL=7, outS=1, outCnt=1. Weighted: outCnt=3.
- Equal sums, stable order: all inS=12, inL={1,2,2,3,3,3} -> list is indices 0,1,2 -> outL=2, outCnt=2, outS=12. Weighted: L1=3, L2=3, tie -> outL=1, outCnt=3.
- Snapshot and start filtering: start, then change inS/inL every cycle and pulse start at T+3 -> single done at T+9, result matches the T snapshot; no second done.
- Reset mid-scan: start at T, rst at T+4 -> busy=0, outputs 0, no done. New start at T+6 -> done at T+15 with the correct result.
- Saturated sums: inS={1023,1023,1023,1023,1023,5}, inL={1,1,2,2,3,3} -> list labels 3,1,1 -> outL=1, outCnt=2, outS=5. Weighted: L3=3, L1=2+1=3 -> outL=3.
